// File: rtl/hazard_ctrl_pkg.sv
// Shared widths, state encodings and register-match helper for hazard_ctrl.
package hazard_ctrl_pkg;

    localparam int REGADDRSIZE = 5;
    localparam int WORDSIZE    = 64;

    localparam logic [REGADDRSIZE-1:0] XZR = 5'd31;

    typedef enum logic [1:0] {
        HZ_RUN     = 2'd0,
        HZ_MEMWAIT = 2'd1,
        HZ_ERROR   = 2'd2
    } hz_state_e;

    // X31 reads as zero, so a write to it never creates a dependency
    function automatic logic src_match(
        input logic [REGADDRSIZE-1:0] rd,
        input logic [REGADDRSIZE-1:0] rn,
        input logic [REGADDRSIZE-1:0] rm,
        input logic                   usesrn,
        input logic                   usesrm
    );
        return (rd != XZR) &&
               ((usesrn && (rn == rd)) || (usesrm && (rm == rd)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_detect.sv
// Source/destination comparators and flag check for the ID stage.
// HAZARD_FORWARDING_EN selects the load-use-only variant.
module hazard_detect
    import hazard_ctrl_pkg::*;
(
    input  logic [REGADDRSIZE-1:0] id_rn,
    input  logic [REGADDRSIZE-1:0] id_rm,
    input  logic                   id_usesrn,
    input  logic                   id_usesrm,
    input  logic                   id_readsflags,
    input  logic [REGADDRSIZE-1:0] idex_rd,
    input  logic                   idex_regwrite,
    input  logic                   idex_memread,
    input  logic                   idex_setsflags,
    input  logic [REGADDRSIZE-1:0] exmem_rd,
    input  logic                   exmem_regwrite,
    input  logic                   exmem_setsflags,
    output logic                   hazard
);

    logic idex_hit;
    logic exmem_hit;

    assign idex_hit  = src_match(idex_rd, id_rn, id_rm,
                                 id_usesrn, id_usesrm);
    assign exmem_hit = src_match(exmem_rd, id_rn, id_rm,
                                 id_usesrn, id_usesrm);

`ifdef HAZARD_FORWARDING_EN
    logic unused_fwd;

    assign unused_fwd = ^{exmem_hit, exmem_regwrite, exmem_setsflags,
                          idex_setsflags, id_readsflags};

    // only a load result arrives too late to forward
    assign hazard = idex_memread && idex_regwrite && idex_hit;
`else
    logic unused_fwd;
    logic reg_haz;
    logic flag_haz;

    assign unused_fwd = idex_memread;

    // write-through regfile: MEM/WB never conflicts
    assign reg_haz  = (idex_regwrite && idex_hit) ||
                      (exmem_regwrite && exmem_hit);
    assign flag_haz = id_readsflags &&
                      (idex_setsflags || exmem_setsflags);
    assign hazard   = reg_haz || flag_haz;
`endif

endmodule

// File: rtl/hazard_ctrl.sv
// LEGv8 pipeline hazard/sequencing controller with memory-wait FSM.
// Optional macro HAZARD_FORWARDING_EN limits data stalls to load-use.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNTW        = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [REGADDRSIZE-1:0] id_rn,
    input  logic [REGADDRSIZE-1:0] id_rm,
    input  logic                   id_usesrn,
    input  logic                   id_usesrm,
    input  logic                   id_readsflags,
    input  logic [REGADDRSIZE-1:0] idex_rd,
    input  logic                   idex_regwrite,
    input  logic                   idex_memread,
    input  logic                   idex_setsflags,
    input  logic [REGADDRSIZE-1:0] exmem_rd,
    input  logic                   exmem_regwrite,
    input  logic                   exmem_setsflags,
    input  logic                   exmem_memop,
    input  logic                   br_taken,
    input  logic                   mem_ready,
    output logic                   pc_we,
    output logic                   ifid_we,
    output logic                   ifid_nop,
    output logic                   idex_nop,
    output logic                   exmem_nop,
    output logic                   memwb_nop,
    output logic                   mem_err,
    output logic [CNTW-1:0]        stall_cnt,
    output logic [CNTW-1:0]        flush_cnt
);

    localparam int WW = $clog2(MEM_TIMEOUT + 1);

    hz_state_e     state;
    logic [WW-1:0] wcnt;
    logic [WW-1:0] wnext;
    logic          hazard;
    logic          freeze;
    logic          flush;
    logic          dstall;

    hazard_detect u_detect (
        .id_rn           (id_rn),
        .id_rm           (id_rm),
        .id_usesrn       (id_usesrn),
        .id_usesrm       (id_usesrm),
        .id_readsflags   (id_readsflags),
        .idex_rd         (idex_rd),
        .idex_regwrite   (idex_regwrite),
        .idex_memread    (idex_memread),
        .idex_setsflags  (idex_setsflags),
        .exmem_rd        (exmem_rd),
        .exmem_regwrite  (exmem_regwrite),
        .exmem_setsflags (exmem_setsflags),
        .hazard          (hazard)
    );

    assign wnext  = wcnt + 1'b1;
    assign freeze = !mem_ready &&
                    (((state == HZ_RUN) && exmem_memop) ||
                     (state == HZ_MEMWAIT));
    assign flush  = (state == HZ_RUN) && !freeze && br_taken;
    assign dstall = (state == HZ_RUN) && !freeze && !br_taken && hazard;

    always_comb begin
        pc_we     = 1'b1;
        ifid_we   = 1'b1;
        ifid_nop  = 1'b0;
        idex_nop  = 1'b0;
        exmem_nop = 1'b0;
        memwb_nop = 1'b0;
        if (reset) begin
            pc_we     = 1'b0;
            ifid_we   = 1'b0;
            ifid_nop  = 1'b1;
            idex_nop  = 1'b1;
            exmem_nop = 1'b1;
            memwb_nop = 1'b1;
        end else if (freeze || (state == HZ_ERROR)) begin
            pc_we     = 1'b0;
            ifid_we   = 1'b0;
            memwb_nop = 1'b1;
        end else if (flush) begin
            ifid_nop  = 1'b1;
            idex_nop  = 1'b1;
            exmem_nop = 1'b1;
        end else if (dstall) begin
            pc_we     = 1'b0;
            ifid_we   = 1'b0;
            idex_nop  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= HZ_RUN;
            wcnt    <= '0;
            mem_err <= 1'b0;
        end else begin
            unique case (state)
                HZ_RUN: begin
                    wcnt <= '0;
                    if (exmem_memop && !mem_ready)
                        state <= HZ_MEMWAIT;
                end
                HZ_MEMWAIT: begin
                    if (mem_ready) begin
                        state <= HZ_RUN;
                        wcnt  <= '0;
                    end else begin
                        wcnt <= wnext;
                        if (wnext >= WW'(MEM_TIMEOUT)) begin
                            state   <= HZ_ERROR;
                            mem_err <= 1'b1;
                        end
                    end
                end
                HZ_ERROR: mem_err <= 1'b1;
                default:  state   <= HZ_RUN;
            endcase
        end
    end

    // counters hold at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if ((freeze || dstall) && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random
// stimulus compared every cycle against an event-level reference model.
module tb_hazard_ctrl;

    localparam int TO   = 4;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    localparam int EV_RST = 0;
    localparam int EV_ERR = 1;
    localparam int EV_FRZ = 2;
    localparam int EV_REL = 3;
    localparam int EV_FL  = 4;
    localparam int EV_ST  = 5;
    localparam int EV_NRM = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    id_rn, id_rm, idex_rd, exmem_rd;
    logic          id_usesrn, id_usesrm, id_readsflags;
    logic          idex_regwrite, idex_memread, idex_setsflags;
    logic          exmem_regwrite, exmem_setsflags, exmem_memop;
    logic          br_taken, mem_ready;
    logic          pc_we, ifid_we, ifid_nop, idex_nop, exmem_nop, memwb_nop;
    logic          mem_err;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic [5:0]    outs;

    int total = 0;
    int bad   = 0;
    bit run_cmp = 0;

    bit m_wait = 0;
    bit m_err  = 0;
    int m_wc   = 0;
    int m_sc   = 0;
    int m_fc   = 0;

    hazard_ctrl #(.MEM_TIMEOUT(TO), .CNTW(CW)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rn           (id_rn),
        .id_rm           (id_rm),
        .id_usesrn       (id_usesrn),
        .id_usesrm       (id_usesrm),
        .id_readsflags   (id_readsflags),
        .idex_rd         (idex_rd),
        .idex_regwrite   (idex_regwrite),
        .idex_memread    (idex_memread),
        .idex_setsflags  (idex_setsflags),
        .exmem_rd        (exmem_rd),
        .exmem_regwrite  (exmem_regwrite),
        .exmem_setsflags (exmem_setsflags),
        .exmem_memop     (exmem_memop),
        .br_taken        (br_taken),
        .mem_ready       (mem_ready),
        .pc_we           (pc_we),
        .ifid_we         (ifid_we),
        .ifid_nop        (ifid_nop),
        .idex_nop        (idex_nop),
        .exmem_nop       (exmem_nop),
        .memwb_nop       (memwb_nop),
        .mem_err         (mem_err),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    always #5 clk = ~clk;

    assign outs = {pc_we, ifid_we, ifid_nop, idex_nop, exmem_nop, memwb_nop};

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp,
                     $time);
        end
    endtask

    // Dependency check from the list of live writers and used sources
    function automatic bit model_hazard();
        bit [4:0] srcs[$];
        bit [4:0] dsts[$];
        if (id_usesrn) srcs.push_back(id_rn);
        if (id_usesrm) srcs.push_back(id_rm);
`ifdef HAZARD_FORWARDING_EN
        if (idex_memread && idex_regwrite) dsts.push_back(idex_rd);
`else
        if (idex_regwrite) dsts.push_back(idex_rd);
        if (exmem_regwrite) dsts.push_back(exmem_rd);
        if (id_readsflags && (idex_setsflags || exmem_setsflags)) return 1;
`endif
        foreach (dsts[d])
            foreach (srcs[s])
                if (dsts[d] != 5'd31 && dsts[d] == srcs[s]) return 1;
        return 0;
    endfunction

    function automatic int classify();
        if (reset) return EV_RST;
        if (m_err) return EV_ERR;
        if (m_wait) return mem_ready ? EV_REL : EV_FRZ;
        if (exmem_memop && !mem_ready) return EV_FRZ;
        if (br_taken) return EV_FL;
        if (model_hazard()) return EV_ST;
        return EV_NRM;
    endfunction

    function automatic logic [5:0] model_out();
        case (classify())
            EV_RST:  return 6'b001111;
            EV_ERR:  return 6'b000001;
            EV_FRZ:  return 6'b000001;
            EV_FL:   return 6'b111110;
            EV_ST:   return 6'b000100;
            default: return 6'b110000;
        endcase
    endfunction

    always @(posedge clk) begin
        int ev;
        ev = classify();
        if (ev == EV_RST) begin
            m_wait = 0; m_err = 0; m_wc = 0; m_sc = 0; m_fc = 0;
        end else begin
            if ((ev == EV_FRZ || ev == EV_ST) && m_sc < MAXC) m_sc++;
            if (ev == EV_FL && m_fc < MAXC) m_fc++;
            if (ev == EV_FRZ) begin
                if (m_wait) begin
                    m_wc++;
                    if (m_wc >= TO) begin
                        m_err = 1;
                        m_wait = 0;
                    end
                end else begin
                    m_wait = 1;
                    m_wc = 0;
                end
            end else if (ev == EV_REL) begin
                m_wait = 0;
                m_wc = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            chk("model_outs", 32'(outs), 32'(model_out()));
            chk("model_err", 32'(mem_err), 32'(m_err));
            chk("model_stall", 32'(stall_cnt), 32'(m_sc));
            chk("model_flush", 32'(flush_cnt), 32'(m_fc));
        end
    end

    task automatic idle();
        id_rn = 0; id_rm = 0; id_usesrn = 0; id_usesrm = 0;
        id_readsflags = 0; idex_rd = 0; idex_regwrite = 0;
        idex_memread = 0; idex_setsflags = 0; exmem_rd = 0;
        exmem_regwrite = 0; exmem_setsflags = 0; exmem_memop = 0;
        br_taken = 0; mem_ready = 1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(); idle(); reset = 1;
        step(); reset = 0;
    endtask

    task automatic load_use();
        idex_memread = 1; idex_regwrite = 1; idex_rd = 5'd1;
        id_rn = 5'd1; id_usesrn = 1;
    endtask

    function automatic logic [4:0] pick_reg();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 5'd31 : 5'(r);
    endfunction

    initial begin
        idle();
        reset = 1;
        step();
        run_cmp = 1;
        @(negedge clk); chk("rst_outs", 32'(outs), 32'b001111);
        step(); reset = 0;
        @(negedge clk);
        chk("rst_stall", 32'(stall_cnt), 0);
        chk("rst_flush", 32'(flush_cnt), 0);
        chk("rst_err", 32'(mem_err), 0);
        chk("rst_norm", 32'(outs), 32'b110000);

        step(); idle(); load_use();
        @(negedge clk); chk("lu_stall", 32'(outs), 32'b000100);
        step(); idle();
        @(negedge clk); chk("lu_release", 32'(outs), 32'b110000);
        chk("lu_cnt", 32'(stall_cnt), 1);

        step(); idle();
        idex_memread = 1; idex_regwrite = 1; idex_rd = 5'd31;
        id_rn = 5'd31; id_usesrn = 1; id_rm = 5'd31; id_usesrm = 1;
        @(negedge clk); chk("xzr", 32'(outs), 32'b110000);

        step(); idle(); load_use(); br_taken = 1;
        @(negedge clk); chk("flush", 32'(outs), 32'b111110);
        step(); idle();
        @(negedge clk);
        chk("flush_cnt", 32'(flush_cnt), 1);
        chk("flush_stall", 32'(stall_cnt), 1);

        do_reset();
        for (int i = 0; i < 3; i++) begin
            idle(); exmem_memop = 1; mem_ready = 0;
            @(negedge clk); chk("mw_freeze", 32'(outs), 32'b000001);
            step();
        end
        exmem_memop = 1; mem_ready = 1;
        @(negedge clk); chk("mw_release", 32'(outs), 32'b110000);
        step(); idle();
        @(negedge clk); chk("mw_cnt", 32'(stall_cnt), 3);

        step(); idle();
        exmem_regwrite = 1; exmem_rd = 5'd2; id_rm = 5'd2; id_usesrm = 1;
`ifdef HAZARD_FORWARDING_EN
        @(negedge clk); chk("add_fwd", 32'(outs), 32'b110000);
`else
        @(negedge clk); chk("add_stall", 32'(outs), 32'b000100);
        step();
        @(negedge clk); chk("add_stall2", 32'(outs), 32'b000100);
`endif
        step(); id_rm = 5'd3;
        @(negedge clk); chk("add_clear", 32'(outs), 32'b110000);
        step(); idle(); idex_setsflags = 1; id_readsflags = 1;
`ifdef HAZARD_FORWARDING_EN
        @(negedge clk); chk("flag_fwd", 32'(outs), 32'b110000);
`else
        @(negedge clk); chk("flag_stall", 32'(outs), 32'b000100);
`endif

        do_reset();
        idle(); exmem_memop = 1; mem_ready = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("to_wait_err", 32'(mem_err), 0);
            step();
        end
        @(negedge clk);
        chk("to_err", 32'(mem_err), 1);
        chk("to_frozen", 32'(outs), 32'b000001);
        step(); idle();
        @(negedge clk);
        chk("err_hold", 32'(outs), 32'b000001);
        chk("err_sticky", 32'(mem_err), 1);
        do_reset();
        @(negedge clk);
        chk("err_clear", 32'(mem_err), 0);
        chk("err_run", 32'(outs), 32'b110000);

        for (int n = 0; n < 3000; n++) begin
            step();
            reset = ($urandom_range(0, 299) == 0);
            id_rn = pick_reg(); id_rm = pick_reg();
            idex_rd = pick_reg(); exmem_rd = pick_reg();
            id_usesrn = 1'($urandom); id_usesrm = 1'($urandom);
            id_readsflags = ($urandom_range(0, 3) == 0);
            idex_regwrite = 1'($urandom); idex_memread = 1'($urandom);
            idex_setsflags = ($urandom_range(0, 3) == 0);
            exmem_regwrite = 1'($urandom);
            exmem_setsflags = ($urandom_range(0, 3) == 0);
            exmem_memop = ($urandom_range(0, 9) < 4);
            br_taken = ($urandom_range(0, 9) < 2);
            mem_ready = (n < 1500) ? ($urandom_range(0, 3) != 0)
                                   : ($urandom_range(0, 3) == 0);
        end
        step(); idle();
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
